// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises and debounces an external reset request, merges a
// software request, and releases core then peripheral resets in a timed sequence.
module reset_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ext_rst_req,
    input  logic       sw_rst_req,
    output logic       rst_core,
    output logic       rst_periph,
    output logic       ready,
    output logic [7:0] rst_count
);

    localparam int unsigned TMAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned DW   = $clog2(DEBOUNCE + 1);

    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] STAGE_LAST = TW'(STAGE_GAP - 1);
    localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE);

    typedef enum logic [1:0] {
        HOLD,
        CORE_UP,
        RUN
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_deb;
    state_t                 r_state;
    logic [TW-1:0]          r_timer;
    logic [7:0]             r_count;
    logic                   r_rst_core;
    logic                   r_rst_periph;
    logic                   r_ready;

    logic w_req_s;
    logic w_req_active;
    logic w_trigger;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ext_rst_req};
        end
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb <= '0;
        end else if (!w_req_s) begin
            r_deb <= '0;
        end else if (r_deb != DEB_MAX) begin
            r_deb <= r_deb + DW'(1);
        end
    end

    assign w_req_active = (r_deb == DEB_MAX);
    assign w_trigger    = w_req_active | sw_rst_req;

    // Outputs are registered alongside the state so they always match its decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HOLD;
            r_timer      <= '0;
            r_count      <= '0;
            r_rst_core   <= 1'b1;
            r_rst_periph <= 1'b1;
            r_ready      <= 1'b0;
        end else if (w_trigger) begin
            r_state      <= HOLD;
            r_timer      <= '0;
            r_rst_core   <= 1'b1;
            r_rst_periph <= 1'b1;
            r_ready      <= 1'b0;
            if (r_state != HOLD && r_count != '1) begin
                r_count <= r_count + 8'd1;
            end
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_timer == HOLD_LAST) begin
                        r_state    <= CORE_UP;
                        r_timer    <= '0;
                        r_rst_core <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                CORE_UP: begin
                    if (r_timer == STAGE_LAST) begin
                        r_state      <= RUN;
                        r_timer      <= '0;
                        r_rst_periph <= 1'b0;
                        r_ready      <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                RUN: begin
                    r_timer <= '0;
                end
                default: begin
                    r_state      <= HOLD;
                    r_timer      <= '0;
                    r_rst_core   <= 1'b1;
                    r_rst_periph <= 1'b1;
                    r_ready      <= 1'b0;
                end
            endcase
        end
    end

    assign rst_core   = r_rst_core;
    assign rst_periph = r_rst_periph;
    assign ready      = r_ready;
    assign rst_count  = r_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random stimulus
// compared every cycle against a time-since-last-reset reference model.
module tb_reset_sequencer;

    localparam int SYNC = 2;
    localparam int DEB  = 3;
    localparam int HOLD = 16;
    localparam int GAP  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ext = 1'b0;
    logic       sw  = 1'b0;
    logic       rst_core;
    logic       rst_periph;
    logic       ready;
    logic [7:0] rst_count;

    int errors = 0;
    int checks = 0;

    reset_sequencer #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE   (DEB),
        .HOLD_CYCLES(HOLD),
        .STAGE_GAP  (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ext_rst_req(ext),
        .sw_rst_req (sw),
        .rst_core   (rst_core),
        .rst_periph (rst_periph),
        .ready      (ready),
        .rst_count  (rst_count)
    );

    always #5 clk = ~clk;

    // Reference: a request is accepted once the last DEB synchronised samples were high;
    // outputs depend only on edges elapsed since the last accepted request or rst.
    int          m_since = 0;
    int          m_cnt   = 0;
    logic [31:0] m_hist  = '0;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin : model
        logic trig;
        trig = sw || (&m_hist[SYNC+DEB-1:SYNC]);
        if (rst) begin
            m_since = 0;
            m_cnt   = 0;
            m_hist  = '0;
            m_valid = 1'b1;
        end else begin
            if (trig) begin
                if (m_since >= HOLD && m_cnt < 255) m_cnt++;
                m_since = 0;
            end else if (m_since < 100000) begin
                m_since++;
            end
            m_hist = {m_hist[30:0], ext};
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (rst_core !== (m_since < HOLD) || rst_periph !== (m_since < HOLD + GAP) ||
                ready !== !(m_since < HOLD + GAP) || rst_count !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL model t=%0t: got core=%b periph=%b ready=%b count=%0d, expected core=%b periph=%b ready=%b count=%0d",
                         $time, rst_core, rst_periph, ready, rst_count,
                         (m_since < HOLD), (m_since < HOLD + GAP), !(m_since < HOLD + GAP), m_cnt);
            end
            checks++;
            if (rst_periph === 1'b0 && rst_core !== 1'b0) begin
                errors++;
                $display("FAIL ordering t=%0t: got core=%b periph=%b, required periph=1 while core=1",
                         $time, rst_core, rst_periph);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 60 && ready !== 1'b1; k++) step();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: got ready=%b, required 1 within 60 cycles", ready);
        end
    endtask

    task automatic wait_core_up();
        for (int k = 0; k < 60 && !(rst_core === 1'b0 && rst_periph === 1'b1); k++) step();
        checks++;
        if (!(rst_core === 1'b0 && rst_periph === 1'b1)) begin
            errors++;
            $display("FAIL wait_core_up: got core=%b periph=%b, required core=0 periph=1", rst_core, rst_periph);
        end
    endtask

    task automatic measure_release(input string name);
        int fall = -1;
        int rdy  = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (fall < 0 && rst_core === 1'b0) fall = k;
            if (rdy < 0 && ready === 1'b1) rdy = k;
        end
        checks++;
        if (fall != HOLD) begin
            errors++;
            $display("FAIL %s_core_release: got %0d cycles, required %0d", name, fall, HOLD);
        end
        checks++;
        if (rdy != HOLD + GAP) begin
            errors++;
            $display("FAIL %s_ready_release: got %0d cycles, required %0d", name, rdy, HOLD + GAP);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({rst_core, rst_periph, ready} !== 3'b110 || rst_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got core/periph/ready=%b%b%b count=%0d, required 110 count=0",
                     rst_core, rst_periph, ready, rst_count);
        end
        rst = 1'b0;
        measure_release("reset");
        checks++;
        if (rst_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, required 0", rst_count);
        end
    endtask

    task automatic test_sw();
        sw = 1'b1;
        step();
        sw = 1'b0;
        checks++;
        if ({rst_core, rst_periph, ready} !== 3'b110) begin
            errors++;
            $display("FAIL sw_assert: got core/periph/ready=%b%b%b, required 110", rst_core, rst_periph, ready);
        end
        checks++;
        if (rst_count !== 8'd1) begin
            errors++;
            $display("FAIL sw_count: got %0d, required 1", rst_count);
        end
        measure_release("sw");
    endtask

    task automatic test_ext();
        bit   quiet = 1'b1;
        int   asrt  = -1;
        int   fall  = -1;
        const int L = 10;
        // Pulse one cycle short of the debounce window must be ignored.
        ext = 1'b1;
        repeat (DEB - 1) step();
        ext = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (ready !== 1'b1 || rst_core !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet || rst_count !== 8'd1) begin
            errors++;
            $display("FAIL ext_short_ignored: got quiet=%b count=%0d, required quiet=1 count=1", quiet, rst_count);
        end
        for (int i = 1; i <= 60; i++) begin
            ext = (i <= L);
            step();
            if (asrt < 0 && rst_core === 1'b1) asrt = i;
            if (asrt >= 0 && fall < 0 && rst_core === 1'b0) fall = i;
        end
        checks++;
        if (asrt != SYNC + DEB + 1) begin
            errors++;
            $display("FAIL ext_latency: got %0d cycles, required %0d", asrt, SYNC + DEB + 1);
        end
        checks++;
        if (fall != L + SYNC + 1 + HOLD) begin
            errors++;
            $display("FAIL ext_release: got cycle %0d, required %0d", fall, L + SYNC + 1 + HOLD);
        end
        checks++;
        if (rst_count !== 8'd2) begin
            errors++;
            $display("FAIL ext_count: got %0d, required 2", rst_count);
        end
    endtask

    task automatic test_retrigger();
        sw = 1'b1;
        step();
        sw = 1'b0;
        wait_core_up();
        sw = 1'b1;
        step();
        sw = 1'b0;
        checks++;
        if (rst_core !== 1'b1 || rst_count !== 8'd4) begin
            errors++;
            $display("FAIL coreup_retrigger: got core=%b count=%0d, required core=1 count=4", rst_core, rst_count);
        end
        repeat (5) step();
        sw = 1'b1;
        step();
        sw = 1'b0;
        checks++;
        if (rst_count !== 8'd4) begin
            errors++;
            $display("FAIL hold_retrigger_count: got %0d, required 4", rst_count);
        end
        measure_release("hold_retrigger");
    endtask

    task automatic test_rst_priority();
        sw = 1'b1;
        step();
        sw = 1'b0;
        wait_ready();
        checks++;
        if (rst_count !== 8'd5) begin
            errors++;
            $display("FAIL pre_rst_count: got %0d, required 5", rst_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({rst_core, rst_periph, ready} !== 3'b110 || rst_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid_run: got core/periph/ready=%b%b%b count=%0d, required 110 count=0",
                     rst_core, rst_periph, ready, rst_count);
        end
        repeat (5) step();
        rst = 1'b1;
        sw  = 1'b1;
        step();
        rst = 1'b0;
        sw  = 1'b0;
        measure_release("rst_mid_hold");
        sw = 1'b1;
        step();
        sw = 1'b0;
        wait_core_up();
        rst = 1'b1;
        sw  = 1'b1;
        step();
        rst = 1'b0;
        sw  = 1'b0;
        checks++;
        if (rst_core !== 1'b1 || rst_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid_coreup: got core=%b count=%0d, required core=1 count=0", rst_core, rst_count);
        end
        wait_ready();
    endtask

    task automatic test_saturation();
        int exp_cnt = 0;
        for (int p = 1; p <= 300; p++) begin
            sw = 1'b1;
            step();
            sw = 1'b0;
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            checks++;
            if (rst_count !== 8'(exp_cnt)) begin
                errors++;
                $display("FAIL saturation pulse %0d: got %0d, required %0d", p, rst_count, exp_cnt);
            end
            wait_ready();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            sw  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 5) == 0) ext = ~ext;
            step();
        end
        rst = 1'b0;
        sw  = 1'b0;
        ext = 1'b0;
        repeat (40) step();
        checks++;
        if (rst_count !== 8'(m_cnt) || ready !== 1'b1) begin
            errors++;
            $display("FAIL random_final: got count=%0d ready=%b, required count=%0d ready=1", rst_count, ready, m_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_ext();
        test_retrigger();
        test_rst_priority();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
